// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register: head entry plus optional skid entry under valid/ready,
// with flush/stall hazard control, control zeroing on bubbles and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W         = 128,
  parameter int CTRL_W         = 16,
  parameter int SKID           = 1,
  parameter int FLUSH_CLR_DATA = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              room;
  logic              accept;
  logic              drain;

  // Handshake: a transfer happens on a side only in a cycle where both valid and ready
  // are high (accept upstream, drain downstream). Hazard controls mask both sides, so a
  // flushed or stalled cycle never moves an entry; valid never waits on ready.
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else if (!stall) begin
      case (state)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (accept && !drain) begin
            state_next = (SKID != 0) ? TWO : ONE;
          end else if (!accept && drain) begin
            state_next = EMPTY;
          end
        end
        TWO:     if (drain) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output logic; without a skid entry, readiness passes straight through from downstream
  always_comb begin
    room      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_ctrl  = '0;
    out_data  = head_data;
    occupancy = state;
    if (SKID != 0) begin
      room = (state != TWO);
    end else begin
      room = (state == EMPTY) || out_ready;
    end
    in_ready  = !rst && !flush && !stall && room;
    out_valid = (state != EMPTY) && !stall && !flush;
    out_ctrl  = out_valid ? head_ctrl : '0;
  end

  // Entry storage; a departing entry leaves its data in the head but its control becomes a no-op
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      head_ctrl <= '0;
      skid_ctrl <= '0;
      if (FLUSH_CLR_DATA != 0) begin
        head_data <= '0;
        skid_data <= '0;
      end
    end else if (!stall) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end else if (accept) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (drain) begin
            head_ctrl <= '0;
          end
        end
        TWO: begin
          if (drain) begin
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
          end
        end
        default: begin
          head_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

  // Bubble counter: every non-reset cycle without a valid output, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios on a skid instance and a no-skid/narrow-counter
// instance, plus a randomized run against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          flush, stall, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          s0_flush, s0_stall, s0_in_valid, s0_out_ready;
  logic [DW-1:0] s0_in_data;
  logic [CW-1:0] s0_in_ctrl;
  logic          s0_in_ready, s0_out_valid;
  logic [DW-1:0] s0_out_data;
  logic [CW-1:0] s0_out_ctrl;
  logic [1:0]    s0_occupancy;
  logic [3:0]    s0_bubble_cnt;

  int total;
  int bad;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) u_s0 (
    .clk(clk), .rst(rst), .flush(s0_flush), .stall(s0_stall),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .out_ctrl(s0_out_ctrl), .occupancy(s0_occupancy), .bubble_cnt(s0_bubble_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send(1'b1, 128'h5A, 16'h00FF);
    s0_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0h want 0", in_ready); end
      total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL reset_s0_in_ready: got %0h want 0", s0_in_ready); end
      tick();
    end
    rst = 1'b0;
    send(1'b0, '0, '0);
    s0_in_valid = 1'b0;
    @(negedge clk);
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
    total++; if (out_ctrl !== '0) begin bad++; $display("FAIL reset_out_ctrl: got %0h want 0", out_ctrl); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0h want 1", in_ready); end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, DW'(i), CW'(i));
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d: got %0h want 1", i, in_ready); end
      if (i > 1) begin
        total++; if (out_data !== DW'(i - 1)) begin bad++; $display("FAIL stream_data%0d: got %0h want %0h", i - 1, out_data, i - 1); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy); end
      end
      tick();
    end
    send(1'b0, '0, '0);
    @(negedge clk);
    total++; if (out_data !== DW'(3)) begin bad++; $display("FAIL stream_data3: got %0h want 3", out_data); end
    total++; if (out_ctrl !== CW'(3)) begin bad++; $display("FAIL stream_ctrl3: got %0h want 3", out_ctrl); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained: got %0h want 0", out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b1, 128'hA, 16'h0011);
    tick();
    send(1'b1, 128'hB, 16'h0022);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one: got %0h want 1", in_ready); end
    tick();
    send(1'b0, '0, '0);
    @(negedge clk);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ2: got %0d want 2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %0h want 0", in_ready); end
    total++; if (out_ctrl !== 16'h0011) begin bad++; $display("FAIL bp_ctrl_a: got %0h want 11", out_ctrl); end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== 128'hA) begin bad++; $display("FAIL bp_data_a: got %0h want a", out_data); end
    tick();
    @(negedge clk);
    total++; if (out_ctrl !== 16'h0022) begin bad++; $display("FAIL bp_ctrl_b: got %0h want 22", out_ctrl); end
    total++; if (out_data !== 128'hB) begin bad++; $display("FAIL bp_data_b: got %0h want b", out_data); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ1: got %0d want 1", occupancy); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty_valid: got %0h want 0", out_valid); end
    total++; if (out_ctrl !== '0) begin bad++; $display("FAIL bp_empty_ctrl: got %0h want 0", out_ctrl); end
    total++; if (out_data !== 128'hB) begin bad++; $display("FAIL bp_empty_data: got %0h want b", out_data); end
  endtask

  task automatic test_stall();
    logic [15:0] bub0;
    out_ready = 1'b0;
    send(1'b1, 128'hC, 16'h0033);
    tick();
    stall = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 128'h6, 16'h0044);
    @(negedge clk);
    bub0 = bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid%0d: got %0h want 0", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d: got %0h want 0", i, in_ready); end
      total++; if (out_ctrl !== '0) begin bad++; $display("FAIL stall_ctrl%0d: got %0h want 0", i, out_ctrl); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stall_occ%0d: got %0d want 1", i, occupancy); end
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if (bubble_cnt !== bub0 + 16'd3) begin bad++; $display("FAIL stall_bubble: got %0d want %0d", bubble_cnt, bub0 + 16'd3); end
    total++; if (out_data !== 128'hC || out_ctrl !== 16'h0033) begin bad++; $display("FAIL stall_keep_c: got %0h/%0h want c/33", out_data, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %0h want 1", in_ready); end
    tick();
    send(1'b0, '0, '0);
    @(negedge clk);
    total++; if (out_data !== 128'h6 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_pending: got %0h/%0h want 6/1", out_data, out_valid); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(1'b1, 128'hD, 16'h0055);
    tick();
    send(1'b1, 128'hE, 16'h0066);
    tick();
    flush = 1'b1;
    send(1'b1, 128'hF, 16'h0077);
    @(negedge clk);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_mask: got %0h/%0h want 0/0", in_ready, out_valid); end
    tick();
    flush = 1'b0;
    send(1'b0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    total++; if (out_ctrl !== '0) begin bad++; $display("FAIL flush_ctrl: got %0h want 0", out_ctrl); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL flush_data: got %0h want 0", out_data); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_f: got %0h want 0", out_valid); end
    tick();
  endtask

  task automatic test_skid0();
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    s0_in_data   = 128'h71;
    s0_in_ctrl   = 16'h0101;
    @(negedge clk);
    total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_empty: got %0h want 1", s0_in_ready); end
    tick();
    s0_in_data = 128'h72;
    s0_in_ctrl = 16'h0202;
    @(negedge clk);
    total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_blocked: got %0h want 0", s0_in_ready); end
    total++; if (s0_occupancy !== 2'd1) begin bad++; $display("FAIL s0_occ: got %0d want 1", s0_occupancy); end
    s0_out_ready = 1'b1;
    #1;
    total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_pass: got %0h want 1", s0_in_ready); end
    tick();
    s0_in_valid = 1'b0;
    @(negedge clk);
    total++; if (s0_out_data !== 128'h72 || s0_occupancy !== 2'd1) begin bad++; $display("FAIL s0_replace: got %0h/%0d want 72/1", s0_out_data, s0_occupancy); end
    total++; if (s0_out_ctrl !== 16'h0202) begin bad++; $display("FAIL s0_ctrl: got %0h want 202", s0_out_ctrl); end
    tick();
    s0_out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_c[$];
    logic [DW-1:0] hold_d;
    int            bub;
    logic          e_ir, e_ov;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
    send(1'b0, '0, '0);
    tick();
    rst = 1'b0;
    hold_d = '0;
    bub = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      send($urandom_range(0, 1) == 1, {$urandom(), $urandom(), $urandom(), $urandom()}, CW'($urandom()));
      out_ready = ($urandom_range(0, 9) < 6);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      e_ir = !flush && !stall && (exp_q.size() < 2);
      e_ov = (exp_q.size() != 0) && !stall && !flush;
      e_oc = e_ov ? exp_c[0] : '0;
      e_od = (exp_q.size() != 0) ? exp_q[0] : hold_d;
      @(negedge clk);
      total++; if (in_ready !== e_ir) begin bad++; $display("FAIL rnd_in_ready c%0d: got %0h want %0h", cyc, in_ready, e_ir); end
      total++; if (out_valid !== e_ov) begin bad++; $display("FAIL rnd_out_valid c%0d: got %0h want %0h", cyc, out_valid, e_ov); end
      total++; if (out_ctrl !== e_oc) begin bad++; $display("FAIL rnd_out_ctrl c%0d: got %0h want %0h", cyc, out_ctrl, e_oc); end
      total++; if (out_data !== e_od) begin bad++; $display("FAIL rnd_out_data c%0d: got %0h want %0h", cyc, out_data, e_od); end
      total++; if (occupancy !== 2'(exp_q.size())) begin bad++; $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy, exp_q.size()); end
      total++; if (bubble_cnt !== 16'(bub)) begin bad++; $display("FAIL rnd_bubble c%0d: got %0d want %0d", cyc, bubble_cnt, bub); end
      @(posedge clk);
      if (!e_ov && bub < 65535) bub++;
      if (flush) begin
        exp_q.delete();
        exp_c.delete();
        hold_d = '0;
      end else begin
        if (e_ov && out_ready) begin
          hold_d = exp_q.pop_front();
          void'(exp_c.pop_front());
        end
        if (in_valid && e_ir) begin
          exp_q.push_back(in_data);
          exp_c.push_back(in_ctrl);
        end
      end
      #1;
    end
    send(1'b0, '0, '0);
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    total++; if (s0_bubble_cnt !== 4'd10) begin bad++; $display("FAIL sat_count10: got %0d want 10", s0_bubble_cnt); end
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    total++; if (s0_bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_count20: got %0d want 15", s0_bubble_cnt); end
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    total++; if (s0_bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", s0_bubble_cnt); end
    total++; if (bubble_cnt !== 16'd23) begin bad++; $display("FAIL sat_wide_count: got %0d want 23", bubble_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
    send(1'b0, '0, '0);
    s0_flush = 1'b0; s0_stall = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_in_data = '0; s0_in_ctrl = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_skid0();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
